lamp_driver: RTL
================

LAMP_DRIVER -- requirements
Module: lamp_driver

Interface
REQ-001 The block SHALL have parameter BLINK_DIV, default 500000: clk cycles per blink half-period.
REQ-002 The block SHALL have parameter WDOG_CYCLES, default 16000000: maximum clk cycles between phase_valid strobes in RUN.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port phase, input, 3 bits: sequencer phase code.
REQ-006 The block SHALL have port phase_valid, input, 1 bit: one-cycle strobe qualifying phase.
REQ-007 The block SHALL have port fault_clr, input, 1 bit: one-cycle fault acknowledge.
REQ-008 The block SHALL have port duty, input, 8 bits: lamp brightness, used only when PWM is compiled in.
REQ-009 The block SHALL have ports lamp_red, lamp_yellow and lamp_green, output, 1 bit each, registered: lamp drives.
REQ-010 The block SHALL have port fault, output, 1 bit, registered: latched fault indication.

Function
REQ-011 The FSM SHALL have states WAIT (no phase received yet), RUN and FAULT.
REQ-012 Phase map in RUN SHALL be:
- 0: red.
- 1: red+yellow.
- 2: green.
- 3: green blinking.
- 4: yellow.
REQ-013 WAIT and FAULT SHALL drive yellow blinking with red and green off.
REQ-014 phase_valid with a code of 0-4 SHALL capture phase and enter or stay in RUN; lamps SHALL reflect the new code exactly 1 cycle after the strobe.
REQ-015 phase_valid with a code of 5-7, in WAIT or RUN, SHALL enter FAULT with fault=1 on the next cycle.
REQ-016 The watchdog counter SHALL clear on every phase_valid and count only in RUN; reaching WDOG_CYCLES SHALL enter FAULT.
REQ-017 In FAULT, phase_valid SHALL be ignored; fault_clr SHALL move to WAIT and clear fault next cycle.
REQ-018 If fault_clr and phase_valid coincide in FAULT, fault_clr SHALL win and the phase SHALL be discarded.
REQ-019 fault_clr outside FAULT SHALL have no effect.
REQ-020 The blink generator SHALL toggle every BLINK_DIV cycles and SHALL restart in the on-half on entry to phase 3, WAIT or FAULT, so the first on-time is a full BLINK_DIV cycles.
REQ-021 A phase_valid that repeats the current code SHALL neither restart the blink generator nor disturb lamp outputs, and SHALL clear the watchdog.
REQ-022 Watchdog and blink counters SHALL saturate or wrap only at their terminal counts and SHALL NOT overflow their widths (sized by $clog2 of the parameter).

Reset
REQ-023 While rst is high, the block SHALL hold state=WAIT, blink in the on-half, watchdog=0, lamps off and fault=0.
REQ-024 The first clk edge after rst deasserts SHALL show lamp_yellow=1.
REQ-025 rst mid-phase or mid-fault SHALL abort immediately, with no pending capture retained.

Configuration
REQ-026 With LAMP_PWM_EN defined, an 8-bit free-running pwm counter SHALL gate each lamp output as lamp AND (pwm_cnt < duty_reg).
REQ-027 With LAMP_PWM_EN defined, duty_reg SHALL sample duty only when pwm_cnt=255 and SHALL reset to 8'hFF.
REQ-028 With LAMP_PWM_EN defined, duty=0 SHALL give lamps constantly off and duty=255 SHALL give 255/256 on-time.
REQ-029 Without LAMP_PWM_EN, the pwm counter SHALL be absent, duty SHALL be ignored, and lamps SHALL be steady on when selected.

Verification (BLINK_DIV=4, WDOG_CYCLES=50)
REQ-030 Reset then idle 20 cycles -> yellow SHALL blink at 4 on / 4 off, red and green SHALL be 0, fault SHALL be 0.
REQ-031 Strobe phases 0,1,2,3,4 every 10 cycles -> lamps SHALL show red, red+yellow, green, green blinking, yellow, each 1 cycle after its strobe.
REQ-032 Strobe phase=6 -> fault=1 and yellow blinking next cycle; fault_clr together with phase_valid(0) -> WAIT, fault=0, red SHALL NOT light.
REQ-033 Strobe phase=2, then no strobes for 50 cycles -> fault SHALL assert at cycle 50; a strobe at cycle 49 SHALL prevent it.
REQ-034 With LAMP_PWM_EN defined, duty=64 in phase 0 -> red SHALL be high 64 of every 256 cycles; changing duty mid-period SHALL take effect only after pwm_cnt=255.
REQ-035 Assert rst during phase 3 blink -> all lamps SHALL be 0 immediately, with WAIT behaviour after release.

Source files
------------

// File: rtl/lamp_driver.sv
// Traffic-lamp driver: phase strobes select the lamp pattern, with a watchdog that
// enters FAULT when strobes stop. Optional PWM dimming is compiled in with LAMP_PWM_EN.
module lamp_driver #(
  parameter int BLINK_DIV   = 500000,
  parameter int WDOG_CYCLES = 16000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] phase,
  input  logic       phase_valid,
  input  logic       fault_clr,
  input  logic [7:0] duty,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV + 1) : 1;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [BW-1:0] B_FULL  = BW'(BLINK_DIV);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          restart;
  logic          red_d, yel_d, grn_d;
  logic          pwm_on;

  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wd_d    = wd_q;
    if (state_q == S_FAULT) begin
      if (fault_clr) state_d = S_WAIT;
    end else if (phase_valid) begin
      wd_d = '0;
      if (phase <= 3'd4) begin
        state_d = S_RUN;
        phase_d = phase;
      end else begin
        state_d = S_FAULT;
      end
    end else if (state_q == S_RUN) begin
      if (wd_q == WD_LAST) state_d = S_FAULT;
      else                 wd_d = wd_q + 1'b1;
    end
    if (state_d != S_RUN) wd_d = '0;
  end

  // The counter holds how many cycles of the current half have been shown, so the
  // entry cycle itself counts as the first of a full on-half.
  assign restart = ((state_d != S_RUN) && (state_d != state_q)) ||
                   ((state_d == S_RUN) && (phase_d == 3'd3) &&
                    !((state_q == S_RUN) && (phase_q == 3'd3)));

  always_comb begin
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    if (restart) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = BW'(1);
    end else if (blink_cnt_q >= B_FULL) begin
      blink_on_d  = ~blink_on_q;
      blink_cnt_d = BW'(1);
    end
  end

  always_comb begin
    red_d = 1'b0;
    yel_d = blink_on_d;
    grn_d = 1'b0;
    if (state_d == S_RUN) begin
      red_d = (phase_d == 3'd0) || (phase_d == 3'd1);
      yel_d = (phase_d == 3'd1) || (phase_d == 3'd4);
      grn_d = (phase_d == 3'd2) || ((phase_d == 3'd3) && blink_on_d);
    end
  end

`ifdef LAMP_PWM_EN
  logic [7:0] pwm_cnt_q, duty_q;

  assign pwm_on = (pwm_cnt_q < duty_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= 8'd0;
      duty_q    <= 8'hFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (pwm_cnt_q == 8'hFF) duty_q <= duty;
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pwm_on      = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      phase_q     <= 3'd0;
      wd_q        <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      lamp_red    <= 1'b0;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wd_q        <= wd_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      lamp_red    <= red_d & pwm_on;
      lamp_yellow <= yel_d & pwm_on;
      lamp_green  <= grn_d & pwm_on;
      fault       <= (state_d == S_FAULT);
    end
  end

endmodule
